// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - E-stage multiply/divide unit owning HI/LO with fixed-latency busy handshake
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  output logic        busy,
  output logic        busy_real,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [31:0] r_hi_tmp;
  logic [31:0] r_lo_tmp;
  logic        r_commit;

  logic        w_is_md;
  logic        w_is_div;
  logic        w_sdiv;
  logic [31:0] w_num;
  logic [31:0] w_den;
  logic [31:0] w_den_safe;
  logic [31:0] w_quo_mag;
  logic [31:0] w_rem_mag;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [63:0] w_prod;

  assign w_is_md  = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
  assign w_is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);
  assign w_sdiv   = (md_op == OP_DIV);

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
  assign w_num      = (w_sdiv && D1[31]) ? -D1 : D1;
  assign w_den      = (w_sdiv && D2[31]) ? -D2 : D2;
  assign w_den_safe = (w_den == 32'd0) ? 32'd1 : w_den;
  assign w_quo_mag  = w_num / w_den_safe;
  assign w_rem_mag  = w_num % w_den_safe;
  assign w_quo      = (w_sdiv && (D1[31] ^ D2[31])) ? -w_quo_mag : w_quo_mag;
  assign w_rem      = (w_sdiv && D1[31]) ? -w_rem_mag : w_rem_mag;

  assign w_prod_s = $signed({{32{D1[31]}}, D1}) * $signed({{32{D2[31]}}, D2});
  assign w_prod_u = {32'd0, D1} * {32'd0, D2};
  assign w_prod   = (md_op == OP_MULT) ? w_prod_s : w_prod_u;

  assign busy_real = busy | w_is_md;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi_tmp <= '0;
      r_lo_tmp <= '0;
      r_commit <= 1'b0;
      busy     <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_md) begin
            r_state <= S_RUN;
            busy    <= 1'b1;
            if (w_is_div) begin
              r_cnt    <= 16'(DIV_CYCLES);
              r_hi_tmp <= w_rem;
              r_lo_tmp <= w_quo;
              r_commit <= (D2 != 32'd0);
            end else begin
              r_cnt    <= 16'(MULT_CYCLES);
              r_hi_tmp <= w_prod[63:32];
              r_lo_tmp <= w_prod[31:0];
              r_commit <= 1'b1;
            end
          end else if (md_op == OP_MTHI) begin
            HI <= D1;
          end else if (md_op == OP_MTLO) begin
            LO <= D1;
          end
        end
        S_RUN: begin
          // md_op is deliberately ignored here; the in-flight op always completes untouched.
          if (r_cnt <= 16'd1) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            r_cnt   <= '0;
            if (r_commit) begin
              HI <= r_hi_tmp;
              LO <= r_lo_tmp;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed table-driven bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] D1;
  logic [31:0] D2;
  logic        busy;
  logic        busy_real;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks;
  int n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs [9];

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .md_op     (md_op),
    .D1        (D1),
    .D2        (D2),
    .busy      (busy),
    .busy_real (busy_real),
    .HI        (HI),
    .LO        (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents op for one cycle, then counts busy cycles while HI/LO must hold.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] d1,
                        input logic [31:0] d2, input int cyc,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int cnt;
    md_op = op; D1 = d1; D2 = d2;
    #1;
    chk({name, " busy_real@start"}, 32'(busy_real), 32'd1);
    chk({name, " busy@start"}, 32'(busy), 32'd0);
    tick();
    md_op = 3'b000; D1 = 32'hA5A5A5A5; D2 = 32'h5A5A5A5A;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      if (HI !== m_hi || LO !== m_lo || busy_real !== 1'b1) begin
        chk({name, " hold HI"}, HI, m_hi);
        chk({name, " hold LO"}, LO, m_lo);
        chk({name, " busy_real in run"}, 32'(busy_real), 32'd1);
      end
      cnt++;
      tick();
    end
    chk({name, " busy cycles"}, 32'(cnt), 32'(cyc));
    chk({name, " HI"}, HI, ehi);
    chk({name, " LO"}, LO, elo);
    chk({name, " busy_real after"}, 32'(busy_real), 32'd0);
    m_hi = ehi;
    m_lo = elo;
  endtask

  initial begin
    int cnt;
    n_checks = 0;
    n_fail   = 0;
    m_hi = 32'd0;
    m_lo = 32'd0;

    vecs[0] = '{3'b001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2] = '{3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 10};
    vecs[4] = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{3'b001, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    vecs[6] = '{3'b011, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7] = '{3'b100, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[8] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

    reset = 1'b1; md_op = 3'b000; D1 = '0; D2 = '0;
    tick();
    tick();
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;
    #1;
    chk("reset busy_real", 32'(busy_real), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].d1, vecs[i].d2,
             vecs[i].cyc, vecs[i].hi, vecs[i].lo);
    end

    // mthi then mtlo on consecutive cycles
    md_op = 3'b101; D1 = 32'h12345678;
    #1;
    chk("mthi busy_real", 32'(busy_real), 32'd0);
    tick();
    chk("mthi HI", HI, 32'h12345678);
    chk("mthi LO kept", LO, m_lo);
    chk("mthi busy", 32'(busy), 32'd0);
    md_op = 3'b110; D1 = 32'hCAFEBABE;
    #1;
    chk("mtlo busy_real", 32'(busy_real), 32'd0);
    tick();
    chk("mtlo LO", LO, 32'hCAFEBABE);
    chk("mtlo HI kept", HI, 32'h12345678);
    chk("mtlo busy", 32'(busy), 32'd0);
    md_op = 3'b111; D1 = 32'hFFFFFFFF;
    tick();
    chk("op111 HI", HI, 32'h12345678);
    chk("op111 LO", LO, 32'hCAFEBABE);
    chk("op111 busy", 32'(busy), 32'd0);
    m_hi = 32'h12345678;
    m_lo = 32'hCAFEBABE;

    // reset in the middle of a divide
    md_op = 3'b011; D1 = 32'd100; D2 = 32'd3;
    tick();
    md_op = 3'b000;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort HI", HI, 32'd0);
    chk("abort LO", LO, 32'd0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) cnt++;
      tick();
    end
    chk("abort no late commit", 32'(cnt), 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;

    // divide by zero leaves preset HI/LO untouched
    md_op = 3'b101; D1 = 32'd5;
    tick();
    md_op = 3'b110; D1 = 32'd6;
    tick();
    m_hi = 32'd5;
    m_lo = 32'd6;
    run_op("div0", 3'b011, 32'd9, 32'd0, 10, 32'd5, 32'd6);
    run_op("divu0", 3'b100, 32'hFFFFFFFF, 32'd0, 10, 32'd5, 32'd6);

    // ops during busy are ignored, then back-to-back div
    md_op = 3'b001; D1 = 32'd2; D2 = 32'd3;
    tick();
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      if (cnt == 0) begin
        md_op = 3'b011; D1 = 32'd100; D2 = 32'd7;
      end else if (cnt == 1) begin
        md_op = 3'b101; D1 = 32'hDEADBEEF;
      end else begin
        md_op = 3'b000;
      end
      if (HI !== m_hi || LO !== m_lo) begin
        chk("ignore hold HI", HI, m_hi);
        chk("ignore hold LO", LO, m_lo);
      end
      cnt++;
      tick();
    end
    md_op = 3'b000;
    chk("ignore busy cycles", 32'(cnt), 32'd5);
    chk("ignore HI", HI, 32'd0);
    chk("ignore LO", LO, 32'd6);
    m_hi = 32'd0;
    m_lo = 32'd6;
    run_op("b2b div", 3'b011, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
